height_history_stats: RTL and testbench

- Parametrised successor to the fixed 10-entry height history. Stores the last DEPTH samples, each WIDTH bits wide, in a circular buffer.
- Adds three things the fixed block lacks: an occupancy count, an indexed read port, and window statistics (min, max, floor average).
- Sits between the height measurement path and the display/UI logic, which reads history by index and shows the statistics.

---
 rtl/height_pkg.sv | 28 ++
 rtl/height_div_seq.sv | 77 +++++++
 rtl/height_history_stats.sv | 195 +++++++++++++++++++
 tb/tb_height_history_stats.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/height_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | height_pkg: shared types, defaults and width helper for the height history |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package height_pkg;

  localparam int HEIGHT_W_DEFAULT      = 8;
  localparam int HISTORY_DEPTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DIV  = 2'd2
  } stats_state_t;

  // Bits needed to hold values 0..value-1 (matches $clog2 for value >= 1).
  function automatic int clog2_w(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage : height_pkg
`default_nettype wire

// File: rtl/height_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | height_div_seq: sequential restoring divider, one quotient bit per cycle   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module height_div_seq
  import height_pkg::*;
#(
  parameter int DIVIDEND_W = 12,
  parameter int DIVISOR_W  = 4,
  parameter int QUOTIENT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [QUOTIENT_W-1:0] quotient
);

  localparam int STEP_W = clog2_w(DIVIDEND_W);
  localparam logic [STEP_W-1:0] c_last_step = STEP_W'(DIVIDEND_W - 1);

  logic                  r_busy;
  logic                  r_done;
  logic [STEP_W-1:0]     r_step;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [DIVIDEND_W-1:0] r_quo;

  logic [DIVISOR_W:0]    w_trial;
  logic                  w_fits;
  logic [DIVISOR_W-1:0]  w_rem_nxt;

  // The remainder stays below the divisor, so it always fits DIVISOR_W bits.
  always_comb begin
    w_trial   = {r_rem, r_quo[DIVIDEND_W-1]};
    w_fits    = (w_trial >= {1'b0, r_divisor});
    w_rem_nxt = w_fits ? DIVISOR_W'(w_trial - {1'b0, r_divisor})
                       : w_trial[DIVISOR_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_step    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
    end else if (start) begin
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_step    <= '0;
      r_rem     <= '0;
      r_divisor <= divisor;
      r_quo     <= dividend;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= {r_quo[DIVIDEND_W-2:0], w_fits};
        r_step <= r_step + 1'b1;
        if (r_step == c_last_step) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_quo[QUOTIENT_W-1:0];

endmodule : height_div_seq
`default_nettype wire

// File: rtl/height_history_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | height_history_stats: circular history of the last DEPTH height samples    |
// | with indexed read, occupancy count and min/max/floor-average statistics.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module height_history_stats
  import height_pkg::*;
#(
  parameter int WIDTH = HEIGHT_W_DEFAULT,
  parameter int DEPTH = HISTORY_DEPTH_DEFAULT,
  parameter int CNT_W = clog2_w(DEPTH + 1),
  parameter int IDX_W = clog2_w(DEPTH),
  parameter int SUM_W = WIDTH + CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             save_height,
  input  logic [WIDTH-1:0] new_height,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic [WIDTH-1:0] min_height,
  output logic [WIDTH-1:0] max_height,
  output logic [WIDTH-1:0] avg_height,
  output logic             stats_valid
);

  localparam int AW = IDX_W + 2;
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_save_prev;
  logic [IDX_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;
  logic [SUM_W-1:0] r_sum;
  logic [WIDTH-1:0] r_rd_data;

  stats_state_t     r_state;
  stats_state_t     w_state_nxt;
  logic [IDX_W-1:0] r_scan_idx;
  logic [WIDTH-1:0] r_scan_min;
  logic [WIDTH-1:0] r_scan_max;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_avg;
  logic             r_stats_valid;

  logic             w_save_edge;
  logic             w_full;
  logic [IDX_W-1:0] w_wptr_nxt;
  logic [SUM_W-1:0] w_sum_nxt;
  logic [AW-1:0]    w_rd_lin;
  logic [IDX_W-1:0] w_rd_phys;
  logic [WIDTH-1:0] w_scan_val;
  logic             w_scan_last;
  logic             w_div_start;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quot;

  assign w_save_edge = save_height & ~r_save_prev;
  assign w_full      = (r_count == c_depth_cnt);
  assign w_wptr_nxt  = (r_wptr == c_last_idx) ? '0 : r_wptr + 1'b1;

  // When full, the slot about to be overwritten is the oldest sample.
  always_comb begin
    w_sum_nxt = r_sum + SUM_W'(new_height);
    if (w_full) w_sum_nxt = w_sum_nxt - SUM_W'(r_mem[r_wptr]);
  end

  always_comb begin
    w_rd_lin  = AW'(r_wptr) + AW'(DEPTH - 1) - AW'(rd_idx);
    w_rd_phys = (w_rd_lin >= AW'(DEPTH)) ? IDX_W'(w_rd_lin - AW'(DEPTH))
                                         : IDX_W'(w_rd_lin);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_save_prev <= 1'b0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_sum       <= '0;
      r_rd_data   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_save_prev <= save_height;
      r_rd_data   <= (CNT_W'(rd_idx) < r_count) ? r_mem[w_rd_phys] : '0;
      if (clear) begin
        r_wptr  <= '0;
        r_count <= '0;
        r_sum   <= '0;
      end else if (w_save_edge) begin
        r_mem[r_wptr] <= new_height;
        r_wptr        <= w_wptr_nxt;
        r_sum         <= w_sum_nxt;
        if (!w_full) r_count <= r_count + 1'b1;
      end
    end
  end

  // Valid entries always occupy physical slots 0..count-1, so the scan walks
  // slots directly; min/max do not depend on age order.
  assign w_scan_val  = r_mem[r_scan_idx];
  assign w_scan_last = (CNT_W'(r_scan_idx) == r_count - 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (clear)            w_state_nxt = IDLE;
        else if (w_save_edge) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (clear)            w_state_nxt = IDLE;
        else if (w_save_edge) w_state_nxt = SCAN;
        else if (w_scan_last) begin
          w_state_nxt = DIV;
          w_div_start = 1'b1;
        end
      end
      DIV: begin
        if (clear)            w_state_nxt = IDLE;
        else if (w_save_edge) w_state_nxt = SCAN;
        else if (w_div_done)  w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_scan_idx    <= '0;
      r_scan_min    <= '0;
      r_scan_max    <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_avg         <= '0;
      r_stats_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (clear) begin
        r_min         <= '0;
        r_max         <= '0;
        r_avg         <= '0;
        r_stats_valid <= 1'b0;
      end else if (w_save_edge) begin
        r_scan_idx    <= '0;
        r_stats_valid <= 1'b0;
      end else if (r_state == SCAN) begin
        r_scan_idx <= r_scan_idx + 1'b1;
        if (r_scan_idx == '0) begin
          r_scan_min <= w_scan_val;
          r_scan_max <= w_scan_val;
        end else begin
          if (w_scan_val < r_scan_min) r_scan_min <= w_scan_val;
          if (w_scan_val > r_scan_max) r_scan_max <= w_scan_val;
        end
      end else if (r_state == DIV && w_div_done) begin
        r_min         <= r_scan_min;
        r_max         <= r_scan_max;
        r_avg         <= w_quot;
        r_stats_valid <= 1'b1;
      end
    end
  end

  height_div_seq #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (CNT_W),
    .QUOTIENT_W (WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (w_div_start),
    .dividend (r_sum),
    .divisor  (r_count),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  assign rd_data     = r_rd_data;
  assign count       = r_count;
  assign full        = w_full;
  assign min_height  = r_min;
  assign max_height  = r_max;
  assign avg_height  = r_avg;
  assign stats_valid = r_stats_valid;

endmodule : height_history_stats
`default_nettype wire

// File: tb/tb_height_history_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_height_history_stats: randomized bench against a queue-based model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_height_history_stats;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int CNT_W = 4;
  localparam int IDX_W = 4;
  localparam int WAIT_LIMIT = 100;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             save_height = 1'b0;
  logic [WIDTH-1:0] new_height = '0;
  logic             clear = 1'b0;
  logic [IDX_W-1:0] rd_idx = '0;
  logic [WIDTH-1:0] rd_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic [WIDTH-1:0] min_height;
  logic [WIDTH-1:0] max_height;
  logic [WIDTH-1:0] avg_height;
  logic             stats_valid;

  int n_checks = 0;
  int n_errors = 0;
  int hist[$];   // index 0 = most recent sample

  height_history_stats #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .save_height (save_height),
    .new_height  (new_height),
    .clear       (clear),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .min_height  (min_height),
    .max_height  (max_height),
    .avg_height  (avg_height),
    .stats_valid (stats_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_push(input int v);
    hist.push_front(v);
    if (hist.size() > DEPTH) void'(hist.pop_back());
  endtask

  task automatic do_save(input int v);
    @(negedge clk);
    save_height = 1'b1;
    new_height  = WIDTH'(v);
    @(negedge clk);
    save_height = 1'b0;
    model_push(v);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    hist.delete();
  endtask

  task automatic wait_stats(input string tag);
    int n;
    n = 0;
    while (stats_valid !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_stats_valid_timeout"}, stats_valid, 1);
  endtask

  task automatic check_stats(input string tag);
    int mn, mx, sm;
    mn = 0; mx = 0; sm = 0;
    foreach (hist[i]) begin
      if (i == 0 || hist[i] < mn) mn = hist[i];
      if (i == 0 || hist[i] > mx) mx = hist[i];
      sm += hist[i];
    end
    check({tag, "_count"}, count, hist.size());
    check({tag, "_full"}, full, hist.size() == DEPTH);
    check({tag, "_min"}, min_height, mn);
    check({tag, "_max"}, max_height, mx);
    check({tag, "_avg"}, avg_height, (hist.size() == 0) ? 0 : sm / hist.size());
    check({tag, "_valid"}, stats_valid, hist.size() != 0);
  endtask

  task automatic check_reads(input string tag);
    int exp;
    for (int i = 0; i < (1 << IDX_W); i++) begin
      @(negedge clk);
      rd_idx = IDX_W'(i);
      @(negedge clk);
      exp = (i < hist.size()) ? hist[i] : 0;
      check($sformatf("%s_rd%0d", tag, i), rd_data, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_min"}, min_height, 0);
    check({tag, "_max"}, max_height, 0);
    check({tag, "_avg"}, avg_height, 0);
    check({tag, "_valid"}, stats_valid, 0);
  endtask

  initial begin
    int v, old_front;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Three samples
    do_save(10); do_save(20); do_save(30);
    wait_stats("three");
    check_stats("three");
    check_reads("three");

    // Read and save in the same cycle return pre-save contents
    @(negedge clk);
    old_front   = hist[0];
    rd_idx      = '0;
    save_height = 1'b1;
    new_height  = 8'd99;
    @(negedge clk);
    check("rd_during_save", rd_data, old_front);
    save_height = 1'b0;
    model_push(99);
    wait_stats("rdsave");

    // Overfill: 1..12 with wrap and eviction
    do_clear();
    for (int i = 1; i <= 12; i++) do_save(i);
    wait_stats("wrap");
    check_stats("wrap");
    check_reads("wrap");

    // Second save edge lands mid-scan of a full buffer
    do_save(7);
    repeat (3) @(negedge clk);
    check("abort_pre_valid", stats_valid, 0);
    save_height = 1'b1;
    new_height  = 8'd8;
    @(negedge clk);
    save_height = 1'b0;
    model_push(8);
    check("abort_post_valid", stats_valid, 0);
    wait_stats("abort");
    check_stats("abort");

    // Hold save high for 5 cycles: one sample
    do_clear();
    @(negedge clk);
    save_height = 1'b1;
    new_height  = 8'd55;
    repeat (5) @(negedge clk);
    save_height = 1'b0;
    model_push(55);
    wait_stats("hold");
    check_stats("hold");
    check_reads("hold");

    // Clear and save edge together: clear wins
    do_clear();
    do_save(4); do_save(9); do_save(1); do_save(250);
    wait_stats("pre_clr");
    check_stats("pre_clr");
    @(negedge clk);
    clear       = 1'b1;
    save_height = 1'b1;
    new_height  = 8'd77;
    @(negedge clk);
    clear       = 1'b0;
    save_height = 1'b0;
    hist.delete();
    repeat (2) @(negedge clk);
    check_stats("clr_save");
    check_reads("clr_save");

    // Reset during DIV: outputs drop without a clock edge
    do_save(100); do_save(150); do_save(50);
    repeat (hist.size() + 5) @(negedge clk);
    check("div_valid_low", stats_valid, 0);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    do_save(200);
    wait_stats("after_rst");
    check_stats("after_rst");

    // Randomized bursts
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        case ($urandom_range(0, 3))
          0:       v = 255;
          1:       v = 0;
          default: v = int'($urandom_range(0, 255));
        endcase
        do_save(v);
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 6)) @(negedge clk);
      end
      if (hist.size() == 0) begin
        @(negedge clk);
        check_stats($sformatf("rnd%0d", it));
      end else if ($urandom_range(0, 2) == 0) begin
        check_reads($sformatf("rnd%0d_busy", it));
        wait_stats($sformatf("rnd%0d", it));
        check_stats($sformatf("rnd%0d", it));
      end else begin
        wait_stats($sformatf("rnd%0d", it));
        check_stats($sformatf("rnd%0d", it));
        check_reads($sformatf("rnd%0d", it));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_height_history_stats
`default_nettype wire
